// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: assembles a length-prefixed little-endian byte
// stream into 32-bit words and writes them from address 0, holding the CPU in reset.
`timescale 1ns/1ps

module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  imem_wren,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [16:0]      DEPTH     = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      words_q, words_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             xfer_s;

    // State and datapath registers.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            word_q  <= 32'd0;
            idx_q   <= 2'd0;
            words_q <= 16'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
        end
    end

    assign xfer_s = rx_valid && rx_ready;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        idx_d   = idx_q;
        words_d = words_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    words_d = 16'd0;
                    idx_d   = 2'd0;
                    tmo_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d[15:8] = rx_data;
                    tmo_d       = '0;
                    state_d     = ({rx_data, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    case (idx_q)
                        2'd0:    word_d[7:0]   = rx_data;
                        2'd1:    word_d[15:8]  = rx_data;
                        2'd2:    word_d[23:16] = rx_data;
                        2'd3:    word_d[31:24] = rx_data;
                        default: word_d        = word_q;
                    endcase
                    idx_d   = idx_q + 2'd1;
                    tmo_d   = '0;
                    state_d = (idx_q == 2'd3) ? S_WRITE : S_DATA;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                words_d = words_q + 16'd1;
                state_d = ((words_q + 16'd1) == len_q) ? S_DONE : S_DATA;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only; words beyond depth are not written.
    assign rx_ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign imem_wren    = (state_q == S_WRITE) && ({1'b0, words_q} < DEPTH);
    assign imem_addr    = words_q[ADDR_WIDTH-1:0];
    assign imem_data    = word_q;
    assign cpu_reset    = (state_q != S_DONE);
    assign busy         = rx_ready || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed byte streams push expected
// memory writes; a monitor pops and compares on every imem_wren.
`timescale 1ns/1ps

module tb_imem_boot_loader;

    localparam int AW  = 2;
    localparam int TMO = 16;

    logic          clk      = 1'b0;
    logic          clk_en   = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [7:0]    rx_data  = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          imem_wren;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cycles[$];

    imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_wren    (imem_wren),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    wr_t mon_e;
    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            wr_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_addr, imem_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("wr_data", imem_data, mon_e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_accept: got no rx_ready within 50 cycles expected acceptance of %0h", b);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            if (gap_max > 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with no clock running.
        #1 reset = 1'b1;
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_wren", 32'(imem_wren), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_data", imem_data, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Two-word load, rx_valid held high.
        exp_q.push_back('{addr: 2'd0, data: 32'h12345678});
        exp_q.push_back('{addr: 2'd1, data: 32'hDEADBEEF});
        wr_cycles.delete();
        pulse_start();
        check("start_rx_ready", 32'(rx_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        rx_valid = 1'b0;
        check("last_wr_cpu_reset", 32'(cpu_reset), 32'd1);
        check("last_wr_done", 32'(done), 32'd0);
        @(negedge clk);
        check("two_done", 32'(done), 32'd1);
        check("two_cpu_reset", 32'(cpu_reset), 32'd0);
        check("two_words", 32'(words_loaded), 32'd2);
        check("two_busy", 32'(busy), 32'd0);
        check("two_wr_count", 32'(wr_cycles.size()), 32'd2);
        if (wr_cycles.size() >= 2)
            check("two_wr_gap", 32'(wr_cycles[1] - wr_cycles[0]), 32'd5);

        // Empty image.
        pulse_start();
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_words", 32'(words_loaded), 32'd0);
        check("empty_cpu_reset", 32'(cpu_reset), 32'd0);

        // Timeout: N=1, two data bytes, then stall.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("tmo_early_error", 32'(error), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_rx_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        check("recover_error", 32'(error), 32'd0);
        check("recover_rx_ready", 32'(rx_ready), 32'd1);
        check("recover_words", 32'(words_loaded), 32'd0);

        // Overflow: N=5 into a 4-word memory (continues from LEN_LO).
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{addr: AW'(i), data: 32'(i + 1)});
        send_byte(8'h05);
        send_byte(8'h00);
        for (int i = 1; i <= 5; i++)
            send_word(32'(i), 0);
        rx_valid = 1'b0;
        check("ovf_no_wren", 32'(imem_wren), 32'd0);
        check("ovf_words_pre", 32'(words_loaded), 32'd4);
        @(negedge clk);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_words", 32'(words_loaded), 32'd5);

        // Backpressure with a start pulse while busy.
        exp_q.push_back('{addr: 2'd0, data: 32'h12345678});
        exp_q.push_back('{addr: 2'd1, data: 32'hDEADBEEF});
        pulse_start();
        send_byte(8'h02);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h00);
        send_word(32'h12345678, 3);
        rx_valid = 1'b0;
        pulse_start();
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_ready", 32'(rx_ready), 32'd1);
        check("busy_start_words", 32'(words_loaded), 32'd1);
        send_word(32'hDEADBEEF, 3);
        rx_valid = 1'b0;
        @(negedge clk);
        check("bp_done", 32'(done), 32'd1);
        check("bp_words", 32'(words_loaded), 32'd2);

        // Abort after 3 data bytes.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("abort_rx_ready", 32'(rx_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Abort during the write cycle drops the strobe at once.
        exp_q.push_back('{addr: 2'd0, data: 32'hCAFEF00D});
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hCAFEF00D, 0);
        rx_valid = 1'b0;
        check("abort_wr_wren_before", 32'(imem_wren), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_wr_wren", 32'(imem_wren), 32'd0);
        check("abort_wr_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
